// File: rtl/pipe_pkg.sv
// Shared types for the MIPS pipeline sequencing controller.
// Imported by pipe_ctrl and its helpers.
package pipe_pkg;

  typedef enum logic [1:0] {
    FETCH,
    LDSTALL,
    DRAIN
  } state_t;

  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam logic [31:0] NOP      = 32'h0;

  function automatic logic is_load_use(
    input logic       memread,
    input logic [4:0] ex_rt,
    input logic [4:0] rs,
    input logic [4:0] rt
  );
    return memread && (ex_rt != REG_ZERO) &&
           ((ex_rt == rs) || (ex_rt == rt));
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating event counter for pipeline
// performance reporting.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: load-use stalls,
// MEM-stage branch redirects, slow imem handling.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             mem_br_taken,
  input  logic [31:0]      mem_br_target,
  input  logic             imem_ready,
  output logic             imem_req,
  output logic             pc_we,
  output logic             pc_sel,
  output logic [31:0]      pc_redirect,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_t      state, state_nx;
  logic [31:0] saved_target;
  logic        save_tgt;
  logic        stall_inc, flush_inc;
  logic        load_use;
  logic        br_now, br_late, lu_hit;
  logic        mem_wait, run;

  assign load_use = is_load_use(ex_memread, ex_rt,
                                id_rs, id_rt);

  // Mutually exclusive view of the priority chain
  assign br_now   = mem_br_taken && imem_ready;
  assign br_late  = mem_br_taken && !imem_ready;
  assign lu_hit   = !mem_br_taken && load_use &&
                    (state == FETCH);
  assign mem_wait = !mem_br_taken && !lu_hit &&
                    !imem_ready;
  assign run      = !mem_br_taken && !lu_hit &&
                    imem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= FETCH;
      saved_target <= '0;
    end else begin
      state <= state_nx;
      if (save_tgt) saved_target <= mem_br_target;
    end
  end

  always_comb begin
    imem_req    = 1'b1;
    pc_we       = 1'b0;
    pc_sel      = 1'b0;
    pc_redirect = mem_br_target;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    state_nx    = state;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    save_tgt    = 1'b0;
    if (!rst_n) begin
      imem_req    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      state_nx    = FETCH;
    end else begin
      unique case (state)
        FETCH, LDSTALL: begin
          unique case (1'b1)
            br_now: begin
              pc_we       = 1'b1;
              pc_sel      = 1'b1;
              ifid_flush  = 1'b1;
              idex_flush  = 1'b1;
              exmem_flush = 1'b1;
              flush_inc   = 1'b1;
              state_nx    = FETCH;
            end
            br_late: begin
              save_tgt    = 1'b1;
              ifid_flush  = 1'b1;
              idex_flush  = 1'b1;
              exmem_flush = 1'b1;
              flush_inc   = 1'b1;
              state_nx    = DRAIN;
            end
            lu_hit: begin
              idex_flush = 1'b1;
              stall_inc  = 1'b1;
              state_nx   = LDSTALL;
            end
            mem_wait: begin
              ifid_flush = 1'b1;
              stall_inc  = 1'b1;
              state_nx   = FETCH;
            end
            run: begin
              pc_we    = 1'b1;
              ifid_we  = 1'b1;
              state_nx = FETCH;
            end
            default: state_nx = FETCH;
          endcase
        end
        DRAIN: begin
          // Wrong-path fetch is still in flight
          pc_redirect = saved_target;
          ifid_flush  = 1'b1;
          if (imem_ready) begin
            pc_we    = 1'b1;
            pc_sel   = 1'b1;
            state_nx = FETCH;
          end else begin
            stall_inc = 1'b1;
          end
        end
        default: state_nx = FETCH;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl
// (CNT_W=4 to reach counter saturation quickly).
module tb_pipe_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    id_rs, id_rt, ex_rt;
  logic          ex_memread;
  logic          mem_br_taken;
  logic [31:0]   mem_br_target;
  logic          imem_ready;
  logic          imem_req, pc_we, pc_sel;
  logic [31:0]   pc_redirect;
  logic          ifid_we, ifid_flush;
  logic          idex_flush, exmem_flush;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [6:0]    ctl;

  int n_chk  = 0;
  int n_pass = 0;

  // {req, pc_we, pc_sel, ifid_we, ifid_fl, idex_fl, exmem_fl}
  localparam logic [6:0] C_RST  = 7'b0000111;
  localparam logic [6:0] C_RUN  = 7'b1101000;
  localparam logic [6:0] C_LU   = 7'b1000010;
  localparam logic [6:0] C_BR   = 7'b1110111;
  localparam logic [6:0] C_BRW  = 7'b1000111;
  localparam logic [6:0] C_WAIT = 7'b1000100;
  localparam logic [6:0] C_DRN  = 7'b1000100;
  localparam logic [6:0] C_DRDY = 7'b1110100;

  pipe_ctrl #(.CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .ex_memread    (ex_memread),
    .ex_rt         (ex_rt),
    .mem_br_taken  (mem_br_taken),
    .mem_br_target (mem_br_target),
    .imem_ready    (imem_ready),
    .imem_req      (imem_req),
    .pc_we         (pc_we),
    .pc_sel        (pc_sel),
    .pc_redirect   (pc_redirect),
    .ifid_we       (ifid_we),
    .ifid_flush    (ifid_flush),
    .idex_flush    (idex_flush),
    .exmem_flush   (exmem_flush),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  always #5 clk = ~clk;

  assign ctl = {imem_req, pc_we, pc_sel, ifid_we,
                ifid_flush, idex_flush, exmem_flush};

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    id_rs         = 5'd0;
    id_rt         = 5'd0;
    ex_rt         = 5'd0;
    ex_memread    = 1'b0;
    mem_br_taken  = 1'b0;
    mem_br_target = 32'h0;
    imem_ready    = 1'b1;

    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_ctl", 32'(ctl), 32'(C_RST));
    end
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_flush", 32'(flush_cnt), 32'd0);

    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("run_ctl", 32'(ctl), 32'(C_RUN));
      step();
    end

    ex_memread = 1'b1;
    ex_rt      = 5'd8;
    id_rs      = 5'd8;
    #1 chk("lu_ctl", 32'(ctl), 32'(C_LU));
    step();
    #1 chk("ldstall_sup", 32'(ctl), 32'(C_RUN));
    chk("lu_stall", 32'(stall_cnt), 32'd1);
    ex_rt = 5'd0;
    id_rs = 5'd0;
    step();
    #1 chk("lu_r0_ctl", 32'(ctl), 32'(C_RUN));
    step();
    chk("lu_r0_stall", 32'(stall_cnt), 32'd1);
    ex_memread = 1'b0;

    mem_br_taken  = 1'b1;
    mem_br_target = 32'h40;
    #1 chk("br_ctl", 32'(ctl), 32'(C_BR));
    chk("br_tgt", pc_redirect, 32'h40);
    step();
    chk("br_flush", 32'(flush_cnt), 32'd1);
    mem_br_taken = 1'b0;
    #1 chk("br_after", 32'(ctl), 32'(C_RUN));
    step();

    mem_br_taken  = 1'b1;
    mem_br_target = 32'h80;
    imem_ready    = 1'b0;
    #1 chk("brw_ctl", 32'(ctl), 32'(C_BRW));
    step();
    mem_br_taken  = 1'b0;
    mem_br_target = 32'h1234;
    for (int i = 0; i < 3; i++) begin
      mem_br_taken = (i == 1);
      #1 chk("drn_ctl", 32'(ctl), 32'(C_DRN));
      chk("drn_tgt", pc_redirect, 32'h80);
      step();
    end
    mem_br_taken = 1'b0;
    chk("drn_stall", 32'(stall_cnt), 32'd4);
    imem_ready = 1'b1;
    #1 chk("drn_rdy", 32'(ctl), 32'(C_DRDY));
    chk("drn_rtgt", pc_redirect, 32'h80);
    step();
    chk("drn_flush", 32'(flush_cnt), 32'd2);
    #1 chk("drn_after", 32'(ctl), 32'(C_RUN));

    mem_br_taken  = 1'b1;
    mem_br_target = 32'h100;
    ex_memread    = 1'b1;
    ex_rt         = 5'd5;
    id_rt         = 5'd5;
    #1 chk("brlu_ctl", 32'(ctl), 32'(C_BR));
    step();
    chk("brlu_stall", 32'(stall_cnt), 32'd4);
    chk("brlu_flush", 32'(flush_cnt), 32'd3);
    mem_br_taken = 1'b0;
    #1 chk("brlu_fetch", 32'(ctl), 32'(C_LU));
    step();
    ex_memread = 1'b0;
    chk("brlu_stall2", 32'(stall_cnt), 32'd5);

    imem_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1 chk("sat_ctl", 32'(ctl), 32'(C_WAIT));
      step();
    end
    chk("sat_15", 32'(stall_cnt), 32'd15);
    step();
    chk("sat_hold", 32'(stall_cnt), 32'd15);

    mem_br_taken  = 1'b1;
    mem_br_target = 32'h200;
    step();
    mem_br_taken  = 1'b0;
    mem_br_target = 32'h0;
    #1 chk("rd_drn", 32'(ctl), 32'(C_DRN));
    chk("rd_tgt", pc_redirect, 32'h200);
    chk("rd_flush", 32'(flush_cnt), 32'd4);
    rst_n = 1'b0;
    #1 chk("rd_rst_ctl", 32'(ctl), 32'(C_RST));
    chk("rd_stall0", 32'(stall_cnt), 32'd0);
    chk("rd_flush0", 32'(flush_cnt), 32'd0);
    step();
    rst_n      = 1'b1;
    imem_ready = 1'b1;
    #1 chk("rd_fetch", 32'(ctl), 32'(C_RUN));
    chk("rd_ptgt", pc_redirect, 32'h0);
    step();
    chk("rd_cnt", 32'({stall_cnt, flush_cnt}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
